regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 125 ++++++++++++
 tb/tb_regfile_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parameterised register file with two registered read ports, one write port, same-cycle forwarding and a sequenced clear.
// Read latency 1 cycle; no backpressure -- while busy the clear sequence owns the array and we/re/clr are dropped.
module regfile_param #(
    parameter int DATA_W   = 24,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    output logic [DATA_W-1:0] dataOutA,
    output logic [DATA_W-1:0] dataOutB,
    output logic              valid,
    output logic              busy
);
    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] dout_a_q, dout_a_d;
    logic [DATA_W-1:0] dout_b_q, dout_b_d;
    logic              valid_q, valid_d;
    logic              wr_en;
    logic              clr_en;
    logic              rd_is_zero;

    // Index 0 is a constant when ZERO_REG is set, so it never forwards either.
    function automatic logic [DATA_W-1:0] read_val(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] stored,
        input logic              wr,
        input logic [ADDR_W-1:0] widx,
        input logic [DATA_W-1:0] wdat
    );
        logic [DATA_W-1:0] v;
        v = stored;
        if ((ZERO_REG != 0) && (idx == '0))
            v = '0;
        else if ((BYPASS != 0) && wr && (idx == widx))
            v = wdat;
        return v;
    endfunction

    assign rd_is_zero = (ZERO_REG != 0) && (rd == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_a_d = dout_a_q;
        dout_b_d = dout_b_q;
        valid_d  = 1'b0;
        wr_en    = 1'b0;
        clr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    wr_en = we && !rd_is_zero;
                    if (re) begin
                        dout_a_d = read_val(rs, regs_q[rs], wr_en, rd, dataIn);
                        dout_b_d = read_val(rt, regs_q[rt], wr_en, rd, dataIn);
                        valid_d  = 1'b1;
                    end
                end
            end
            CLEAR: begin
                clr_en = 1'b1;
                if (cnt_q == ADDR_W'(NREGS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dout_a_q <= '0;
            dout_b_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (clr_en) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_en) begin
            regs_q[rd] <= dataIn;
        end
    end

    assign dataOutA = dout_a_q;
    assign dataOutB = dout_b_q;
    assign valid    = valid_q;
    assign busy     = (state_q == CLEAR);
endmodule

// File: tb/tb_regfile_param.sv
// Drives two register files (ZERO_REG/BYPASS on, and both off) with shared stimulus, scoreboarded against an array model.
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  rs = '0, rt = '0, rd = '0;
    logic [23:0] dataIn = '0;
    logic        we = 1'b0, re = 1'b0, clr = 1'b0;
    logic [23:0] a0, b0, a1, b1;
    logic        v0, v1, bz0, bz1;

    always #5 clk = ~clk;

    regfile_param u0 (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .dataIn(dataIn),
        .we(we), .re(re), .clr(clr),
        .dataOutA(a0), .dataOutB(b0), .valid(v0), .busy(bz0)
    );

    regfile_param #(.DATA_W(24), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .dataIn(dataIn),
        .we(we), .re(re), .clr(clr),
        .dataOutA(a1), .dataOutB(b1), .valid(v1), .busy(bz1)
    );

    typedef struct packed {
        logic [1:0]        v;
        logic [1:0]        bz;
        logic [1:0][23:0]  a;
        logic [1:0][23:0]  b;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m;
    int          errors = 0;
    int          checks = 0;

    logic [23:0] mem  [2][8];
    logic [23:0] outa [2];
    logic [23:0] outb [2];
    int          clear_left;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) mem[k][i] = '0;
            outa[k] = '0;
            outb[k] = '0;
        end
        clear_left = 0;
    endtask

    // Instance 0: r0 reads as zero and writes forward; instance 1: neither.
    function automatic logic [23:0] model_rd(input int k, input logic [2:0] idx, input logic w,
                                             input logic [2:0] d, input logic [23:0] din);
        if (k == 0 && idx == 3'd0) return 24'd0;
        if (k == 0 && w && d == idx) return din;
        return mem[k][idx];
    endfunction

    task automatic step(input logic w, input logic r, input logic c, input logic [2:0] s,
                        input logic [2:0] t, input logic [2:0] d, input logic [23:0] din);
        exp_t e;
        bit   clearing;
        @(negedge clk);
        we = w; re = r; clr = c; rs = s; rt = t; rd = d; dataIn = din;
        clearing = (clear_left > 0);
        for (int k = 0; k < 2; k++) begin
            e.v[k] = 1'b0;
            if (clearing) begin
                mem[k][8 - clear_left] = '0;
            end else if (!c) begin
                if (r) begin
                    outa[k] = model_rd(k, s, w, d, din);
                    outb[k] = model_rd(k, t, w, d, din);
                    e.v[k]  = 1'b1;
                end
                if (w && !(k == 0 && d == 3'd0)) mem[k][d] = din;
            end
            e.a[k] = outa[k];
            e.b[k] = outb[k];
        end
        if (clearing) clear_left--;
        else if (c) clear_left = 8;
        e.bz = (clear_left > 0) ? 2'b11 : 2'b00;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 24'd0);
    endtask

    task automatic fill();
        for (int i = 1; i < 8; i++)
            step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'(i), 24'h100000 + 24'(i * 24'h1111));
        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 24'h0A0A0A);
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i += 2)
            step(1'b0, 1'b1, 1'b0, 3'(i), 3'(i + 1), 3'd0, 24'd0);
        idle(1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy0"},  {23'd0, bz0}, 24'd0);
        chk({tag, "_valid0"}, {23'd0, v0},  24'd0);
        chk({tag, "_a0"}, a0, 24'd0);
        chk({tag, "_b0"}, b0, 24'd0);
        chk({tag, "_busy1"},  {23'd0, bz1}, 24'd0);
        chk({tag, "_valid1"}, {23'd0, v1},  24'd0);
        chk({tag, "_a1"}, a1, 24'd0);
        chk({tag, "_b1"}, b1, 24'd0);
    endtask

    // Monitor: one expected record per consumed edge, compared shortly after the edge.
    always @(posedge clk) begin
        #2;
        if (!rst && exp_q.size() > 0) begin
            m = exp_q.pop_front();
            chk("valid_u0", {23'd0, v0},  {23'd0, m.v[0]});
            chk("busy_u0",  {23'd0, bz0}, {23'd0, m.bz[0]});
            chk("dataA_u0", a0, m.a[0]);
            chk("dataB_u0", b0, m.b[0]);
            chk("valid_u1", {23'd0, v1},  {23'd0, m.v[1]});
            chk("busy_u1",  {23'd0, bz1}, {23'd0, m.bz[1]});
            chk("dataA_u1", a1, m.a[1]);
            chk("dataB_u1", b1, m.b[1]);
        end
    end

    initial begin
        model_reset();
        #3;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Write then read back with r0 on port B.
        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd3, 24'hABCDEF);
        step(1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 3'd0, 24'd0);
        idle(1);

        // Same-cycle write/read of r5: forwarded on u0, old contents on u1.
        step(1'b1, 1'b1, 1'b0, 3'd5, 3'd5, 3'd5, 24'hC0FFEE);
        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd5, 24'h000001);
        step(1'b1, 1'b1, 1'b0, 3'd5, 3'd2, 3'd5, 24'h123456);
        idle(1);

        // Writes to r0, including a concurrent read of r0.
        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 24'hFFFFFF);
        step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 24'd0);
        step(1'b1, 1'b1, 1'b0, 3'd0, 3'd5, 3'd0, 24'h5A5A5A);
        idle(1);

        // Clear with a competing write; busy must last exactly 8 cycles.
        fill();
        read_all();
        step(1'b1, 1'b1, 1'b1, 3'd2, 3'd1, 3'd2, 24'h777777);
        idle(9);
        read_all();

        // Clear with re held throughout: outputs hold and valid stays low.
        fill();
        step(1'b0, 1'b1, 1'b0, 3'd7, 3'd6, 3'd0, 24'd0);
        step(1'b0, 1'b1, 1'b1, 3'd1, 3'd2, 3'd0, 24'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 3'd4, 3'd5, 3'(i), 24'hBEEF00);
        step(1'b0, 1'b1, 1'b0, 3'd7, 3'd0, 3'd0, 24'd0);
        idle(1);
        read_all();

        // Asynchronous reset in the 4th clear cycle.
        fill();
        step(1'b0, 1'b1, 1'b0, 3'd3, 3'd4, 3'd0, 24'd0);
        step(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 24'd0);
        idle(3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        we = 1'b0; re = 1'b0; clr = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        read_all();

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0),
                 3'($urandom), 3'($urandom), 3'($urandom), 24'($urandom));
        end
        idle(10);
        read_all();
        @(posedge clk);
        #4;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
